bus_gnrtr_n_rbtr: RTL and testbench

Shared-bus packet generator and round-robin arbiter connecting `drvrs` device FIFOs over `bits` independent buses. On each bus, one pending source FIFO at a time gets the grant. The block pops that FIFO's head packet and pushes the packet into the FIFO(s) of the addressed destination, or into all other devices for broadcast. It is the interconnect core of the data-bus subsystem; device-side FIFOs are external.

---
 rtl/bus_gnrtr_n_rbtr.sv | 107 ++++++++++
 tb/tb_bus_gnrtr_n_rbtr.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus packet mover: per bus, round-robin pick a pending source, pop it, push to its destination(s).
// Latency: pop one cycle after grant, push one cycle after pop; one packet per 3 cycles per bus.
module bus_gnrtr_n_rbtr #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]             pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]             pop,
  output logic [bits-1:0][drvrs-1:0]             push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  // Scan last+1 .. last+drvrs; iterating from the far end lets the nearest request win.
  function automatic logic [IW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                            input logic [IW-1:0]    lst);
    int idx;
    rr_pick = lst;
    for (int j = drvrs; j >= 1; j--) begin
      idx = (int'(lst) + j) % drvrs;
      if (req[idx]) rr_pick = IW'(idx);
    end
  endfunction

  function automatic logic [drvrs-1:0] dest_mask(input logic [7:0]    d,
                                                 input logic [IW-1:0] s);
    dest_mask = '0;
    if (d == broadcast) begin
      dest_mask    = '1;
      dest_mask[s] = 1'b0;
    end else if (int'(d) < drvrs) begin
      dest_mask[d[IW-1:0]] = 1'b1;
    end
  endfunction

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t             state, state_nxt;
    logic [IW-1:0]      src, last, grant;
    logic [pckg_sz-1:0] pkt, dpush_q;
    logic [drvrs-1:0]   pop_nxt, push_nxt, pop_q, push_q;
    logic               any_req;

    assign any_req = |pndng[b];
    assign grant   = rr_pick(pndng[b], last);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state <= IDLE;
        src   <= '0;
        last  <= IW'(drvrs - 1);
        pkt   <= '0;
      end else begin
        state <= state_nxt;
        if (state == IDLE && any_req) begin
          pkt  <= D_pop[b][grant];
          src  <= grant;
          last <= grant;
        end
      end
    end

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (any_req) state_nxt = POP;
        POP:     state_nxt = PUSH;
        PUSH:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Strobes are computed one state ahead so they leave the block straight from flops.
    always_comb begin
      pop_nxt  = '0;
      push_nxt = '0;
      if (state == IDLE && any_req) pop_nxt[grant] = 1'b1;
      if (state == POP) push_nxt = dest_mask(pkt[pckg_sz-1 -: 8], src);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pop_q   <= '0;
        push_q  <= '0;
        dpush_q <= '0;
      end else begin
        pop_q  <= pop_nxt;
        push_q <= push_nxt;
        if (state == POP) dpush_q <= pkt;
      end
    end

    assign pop[b]  = pop_q;
    assign push[b] = push_q;
    for (genvar k = 0; k < drvrs; k++) begin : g_lane
      assign D_push[b][k] = dpush_q;
    end
  end

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Directed bench for bus_gnrtr_n_rbtr: one bus, four devices, 16-bit packets.
module tb_bus_gnrtr_n_rbtr;
  logic                   clk = 1'b0;
  logic                   reset;
  logic [0:0][3:0]        pndng, pop, push;
  logic [0:0][3:0][15:0]  D_pop, D_push;
  int                     n_chk  = 0;
  int                     n_pass = 0;

  always #5 clk = ~clk;

  bus_gnrtr_n_rbtr #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pndng = '0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_pop;

    // Reset held with everyone pending: nothing may move.
    reset = 1'b0;
    pndng = '0;
    pndng[0] = 4'b1111;
    D_pop = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pop", 64'(pop), 64'h0);
      chk("rst_push", 64'(push), 64'h0);
      chk("rst_dpush", 64'(D_push), 64'h0);
    end
    reset = 1'b1;
    pndng = '0;
    tick();

    // Unicast 1 -> 2
    do_reset();
    pndng[0] = 4'b0010;
    D_pop[0][1] = 16'h02AB;
    tick();
    chk("uni_pop", 64'(pop), 64'h2);
    chk("uni_push0", 64'(push), 64'h0);
    pndng = '0;
    tick();
    chk("uni_pop_end", 64'(pop), 64'h0);
    chk("uni_push", 64'(push), 64'h4);
    chk("uni_data", 64'(D_push[0][2]), 64'h02AB);
    tick();
    chk("uni_push_end", 64'(push), 64'h0);
    chk("uni_hold", 64'(D_push), {4{16'h02AB}});

    // Broadcast from 3
    do_reset();
    pndng[0] = 4'b1000;
    D_pop[0][3] = 16'hFF5A;
    tick();
    chk("bc_pop", 64'(pop), 64'h8);
    pndng = '0;
    tick();
    chk("bc_push", 64'(push), 64'h7);
    chk("bc_data", 64'(D_push), {4{16'hFF5A}});
    tick();
    chk("bc_push_end", 64'(push), 64'h0);

    // Round-robin with all four continuously pending
    do_reset();
    for (int k = 0; k < 4; k++) D_pop[0][k] = 16'(k);
    pndng[0] = 4'b1111;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_pop = (k % 3 == 1) ? 4'(1 << order[(k - 1) / 3]) : 4'b0000;
      chk($sformatf("rr_pop_%0d", k), 64'(pop), 64'(exp_pop));
    end
    pndng = '0;
    repeat (3) tick();

    // Invalid destination: popped, never pushed
    do_reset();
    pndng[0] = 4'b0001;
    D_pop[0][0] = 16'h0711;
    tick();
    chk("inv_pop", 64'(pop), 64'h1);
    pndng = '0;
    tick();
    chk("inv_push", 64'(push), 64'h0);
    tick();
    chk("inv_push2", 64'(push), 64'h0);
    pndng[0] = 4'b0100;
    D_pop[0][2] = 16'h0000;
    tick();
    chk("inv_idle_regrant", 64'(pop), 64'h4);
    pndng = '0;
    repeat (3) tick();

    // Reset during the POP cycle of a transfer from device 2
    do_reset();
    pndng[0] = 4'b0100;
    D_pop[0][2] = 16'h0133;
    tick();
    chk("mid_pop", 64'(pop), 64'h4);
    pndng[0] = 4'b0101;
    reset = 1'b0;
    #1;
    chk("mid_pop_clr", 64'(pop), 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mid_push", 64'(push), 64'h0);
    end
    reset = 1'b1;
    tick();
    chk("mid_first_grant", 64'(pop), 64'h1);
    chk("mid_no_push", 64'(push), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
